// File: rtl/sdram_port_arbiter.sv
// Two-requester arbiter in front of one Avalon-MM SDRAM controller port: round-robin grant with burst lock,
// pipelined reads routed back through an in-order tag FIFO. Define SDRAM_ARB_PRIORITY_EN for fixed rq0 priority.
module sdram_port_arbiter #(
  parameter int ADDR_W      = 25,
  parameter int DATA_W      = 16,
  parameter int MAX_PENDING = 8,
  parameter int GRANT_BURST = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [ADDR_W-1:0]             rq0_address,
  input  logic                          rq0_read,
  input  logic                          rq0_write,
  input  logic [DATA_W-1:0]             rq0_writedata,
  input  logic [DATA_W/8-1:0]           rq0_byteenable,
  output logic                          rq0_waitrequest,
  output logic [DATA_W-1:0]             rq0_readdata,
  output logic                          rq0_readdatavalid,
  input  logic [ADDR_W-1:0]             rq1_address,
  input  logic                          rq1_read,
  input  logic                          rq1_write,
  input  logic [DATA_W-1:0]             rq1_writedata,
  input  logic [DATA_W/8-1:0]           rq1_byteenable,
  output logic                          rq1_waitrequest,
  output logic [DATA_W-1:0]             rq1_readdata,
  output logic                          rq1_readdatavalid,
  output logic [ADDR_W-1:0]             av_address,
  output logic                          av_read,
  output logic                          av_write,
  output logic [DATA_W-1:0]             av_writedata,
  output logic [DATA_W/8-1:0]           av_byteenable,
  input  logic                          av_waitrequest,
  input  logic [DATA_W-1:0]             av_readdata,
  input  logic                          av_readdatavalid,
  output logic [$clog2(MAX_PENDING):0]  pending_count,
  output logic                          err_orphan
);

  localparam int PTR_W   = $clog2(MAX_PENDING);
  localparam int CNT_W   = PTR_W + 1;
  localparam int BURST_W = $clog2(GRANT_BURST + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_G0   = 2'd1,
    S_G1   = 2'd2
  } state_t;

  state_t             r_state;
  logic [BURST_W-1:0] r_burst;
  logic               r_tag [MAX_PENDING];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_err;
`ifndef SDRAM_ARB_PRIORITY_EN
  logic               r_last_served;
`endif

  logic               w_req0;
  logic               w_req1;
  logic               w_granted;
  logic               w_sel1;
  logic               w_sel_read;
  logic               w_stall;
  logic               w_pop;
  logic               w_push;
  logic               w_read_block;
  logic               w_accept;
  logic               w_cur_req;
  logic               w_oth_req;
  logic [BURST_W-1:0] w_burst_inc;
  logic               w_hit_limit;
  logic               w_leave;

  assign w_req0    = rq0_read | rq0_write;
  assign w_req1    = rq1_read | rq1_write;
  assign w_granted = (r_state != S_IDLE);
  assign w_sel1    = (r_state == S_G1);

  // A return arriving this cycle frees a slot, so a full FIFO still lets the stalled read through.
  assign w_pop        = av_readdatavalid & (r_count != '0);
  assign w_read_block = (r_count == CNT_W'(MAX_PENDING)) & ~w_pop;

  // NOTE: every signal driven here gets a default first so no path leaves a latch behind.
  always_comb begin
    av_address     = rq0_address;
    av_writedata   = rq0_writedata;
    av_byteenable  = rq0_byteenable;
    w_sel_read     = rq0_read;
    av_write       = w_granted & rq0_write;
    if (w_sel1) begin
      av_address    = rq1_address;
      av_writedata  = rq1_writedata;
      av_byteenable = rq1_byteenable;
      w_sel_read    = rq1_read;
      av_write      = rq1_write;
    end
    av_read = w_granted & w_sel_read & ~w_read_block;
  end

  assign w_stall         = av_waitrequest | (w_read_block & w_sel_read);
  assign rq0_waitrequest = (r_state != S_G0) | w_stall;
  assign rq1_waitrequest = (r_state != S_G1) | w_stall;

  assign w_accept = (av_read | av_write) & ~av_waitrequest;
  assign w_push   = w_accept & av_read;

  assign rq0_readdata      = av_readdata;
  assign rq1_readdata      = av_readdata;
  assign rq0_readdatavalid = w_pop & ~r_tag[r_rd_ptr];
  assign rq1_readdatavalid = w_pop &  r_tag[r_rd_ptr];
  assign pending_count     = r_count;
  assign err_orphan        = r_err;

  assign w_cur_req   = w_sel1 ? w_req1 : w_req0;
  assign w_oth_req   = w_sel1 ? w_req0 : w_req1;
  assign w_burst_inc = r_burst + BURST_W'(w_accept);
  assign w_hit_limit = w_accept & (w_burst_inc == BURST_W'(GRANT_BURST));
`ifdef SDRAM_ARB_PRIORITY_EN
  // G0 holds as long as rq0 keeps asking; G1 yields on the first acceptance once rq0 wants in.
  assign w_leave = ~w_cur_req | (w_sel1 & (w_hit_limit | (w_accept & w_req0)));
`else
  assign w_leave = ~w_cur_req | w_hit_limit;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_burst <= '0;
`ifndef SDRAM_ARB_PRIORITY_EN
      r_last_served <= 1'b1;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
`ifdef SDRAM_ARB_PRIORITY_EN
          if (w_req0)      r_state <= S_G0;
          else if (w_req1) r_state <= S_G1;
`else
          if (w_req0 & (r_last_served | ~w_req1)) r_state <= S_G0;
          else if (w_req1)                        r_state <= S_G1;
`endif
        end
        default: begin
          if (w_leave) begin
            r_burst <= '0;
`ifndef SDRAM_ARB_PRIORITY_EN
            r_last_served <= w_sel1;
`endif
            if (w_oth_req) r_state <= w_sel1 ? S_G0 : S_G1;
            else           r_state <= S_IDLE;
          end else begin
            r_burst <= w_burst_inc;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (av_readdatavalid & (r_count == '0)) r_err <= 1'b1;
    end
  end

  // NOTE: tag storage is not reset; entries are only read after being written behind the pointers.
  always_ff @(posedge clk) begin
    if (w_push) r_tag[r_wr_ptr] <= w_sel1;
  end

endmodule
